// File: rtl/stream_requantizer.sv
// Requantiser for an AXI-Stream accumulator stream: per-channel bias add, round-half-up shift, saturation.
// Optional saturation event counter enabled by defining REQUANT_SAT_COUNT_EN.
module stream_requantizer #(
  parameter int s_axis_input_WIDTH   = 32,
  parameter int s_axis_input_SIGNED  = 1,
  parameter int m_axis_output_WIDTH  = 8,
  parameter int m_axis_output_SIGNED = 1,
  parameter int BIAS_WIDTH           = 16,
  parameter int CHANNELS             = 16,
  parameter int SHIFT_WIDTH          = 5,
  localparam int ADDR_WIDTH          = $clog2(CHANNELS)
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic [s_axis_input_WIDTH-1:0]   s_axis_input_tdata,
  input  logic                            s_axis_input_tvalid,
  output logic                            s_axis_input_tready,
  input  logic                            s_axis_input_tlast,
  output logic [m_axis_output_WIDTH-1:0]  m_axis_output_tdata,
  output logic                            m_axis_output_tvalid,
  input  logic                            m_axis_output_tready,
  output logic                            m_axis_output_tlast,
  input  logic [SHIFT_WIDTH-1:0]          cfg_shift,
  input  logic                            bias_wr_en,
  input  logic [ADDR_WIDTH-1:0]           bias_wr_addr,
  input  logic [BIAS_WIDTH-1:0]           bias_wr_data,
  output logic [31:0]                     sat_count
);

  localparam int IW   = s_axis_input_WIDTH;
  localparam int OW   = m_axis_output_WIDTH;
  localparam int SUMW = IW + 2;
  // One extra bit so the rounding increment can never overflow the shifted operand.
  localparam int RW   = SUMW + 1;
  localparam logic signed [RW-1:0] ONE = {{(RW-1){1'b0}}, 1'b1};
  localparam logic signed [RW-1:0] OMAX_S = (m_axis_output_SIGNED != 0) ?
                                            ((ONE <<< (OW - 1)) - ONE) : ((ONE <<< OW) - ONE);
  localparam logic signed [RW-1:0] OMIN_S = (m_axis_output_SIGNED != 0) ?
                                            (-(ONE <<< (OW - 1))) : {RW{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] CH_LAST = ADDR_WIDTH'(CHANNELS - 1);

  logic                          adv1_s;
  logic                          adv2_s;
  logic                          accept_s;
  logic [ADDR_WIDTH-1:0]         ch_r;
  logic [BIAS_WIDTH-1:0]         bias_r [CHANNELS];
  logic [BIAS_WIDTH-1:0]         bias_sel_s;
  logic signed [SUMW-1:0]        x_s;
  logic signed [SUMW-1:0]        b_s;
  logic signed [SUMW-1:0]        sum_s;
  logic                          v1_r;
  logic signed [SUMW-1:0]        sum1_r;
  logic [SHIFT_WIDTH-1:0]        sh1_r;
  logic                          last1_r;
  logic                          v2_r;
  logic [OW-1:0]                 data2_r;
  logic                          last2_r;
  logic [31:0]                   sh_eff_s;
  logic signed [RW-1:0]          ext_s;
  logic signed [RW-1:0]          rnd_s;
  logic signed [RW-1:0]          r_s;
  logic [OW-1:0]                 q_s;

  assign adv2_s               = !v2_r || m_axis_output_tready;
  assign adv1_s               = !v1_r || adv2_s;
  assign s_axis_input_tready  = adv1_s && !ap_rst;
  assign accept_s             = s_axis_input_tvalid && s_axis_input_tready;
  assign m_axis_output_tvalid = v2_r;
  assign m_axis_output_tdata  = data2_r;
  assign m_axis_output_tlast  = last2_r;

  // Stage-1 operands: extended input plus sign-extended bias of the current channel.
  always_comb begin
    if (s_axis_input_SIGNED != 0) begin
      x_s = {{2{s_axis_input_tdata[IW-1]}}, s_axis_input_tdata};
    end else begin
      x_s = {2'b00, s_axis_input_tdata};
    end
    bias_sel_s = bias_r[ch_r];
    b_s        = {{(SUMW - BIAS_WIDTH){bias_sel_s[BIAS_WIDTH-1]}}, bias_sel_s};
    sum_s      = x_s + b_s;
  end

  // Bias table; a read in the same cycle as a write still sees the old entry.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        bias_r[i] <= {BIAS_WIDTH{1'b0}};
      end
    end else if (bias_wr_en && (32'(bias_wr_addr) < 32'(CHANNELS))) begin
      bias_r[bias_wr_addr] <= bias_wr_data;
    end
  end

  // Stage-1 capture and channel tracking; tlast restarts the channel sequence.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v1_r    <= 1'b0;
      sum1_r  <= {SUMW{1'b0}};
      sh1_r   <= {SHIFT_WIDTH{1'b0}};
      last1_r <= 1'b0;
      ch_r    <= {ADDR_WIDTH{1'b0}};
    end else begin
      if (adv1_s) begin
        v1_r <= accept_s;
      end
      if (accept_s) begin
        sum1_r  <= sum_s;
        sh1_r   <= cfg_shift;
        last1_r <= s_axis_input_tlast;
        if (s_axis_input_tlast) begin
          ch_r <= {ADDR_WIDTH{1'b0}};
        end else if (ch_r == CH_LAST) begin
          ch_r <= {ADDR_WIDTH{1'b0}};
        end else begin
          ch_r <= ch_r + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Stage-2 arithmetic: clamp the shift, round half up, then saturate to the output range.
  always_comb begin
    ext_s = {sum1_r[SUMW-1], sum1_r};
    if (32'(sh1_r) >= 32'(SUMW)) begin
      sh_eff_s = 32'(SUMW - 1);
    end else begin
      sh_eff_s = 32'(sh1_r);
    end
    if (sh_eff_s == 32'd0) begin
      rnd_s = {RW{1'b0}};
      r_s   = ext_s;
    end else begin
      rnd_s = ONE <<< (sh_eff_s - 32'd1);
      r_s   = (ext_s + rnd_s) >>> sh_eff_s;
    end
    if (r_s > OMAX_S) begin
      q_s = OMAX_S[OW-1:0];
    end else if (r_s < OMIN_S) begin
      q_s = OMIN_S[OW-1:0];
    end else begin
      q_s = r_s[OW-1:0];
    end
  end

  // Output register; data and last hold while the downstream stalls.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v2_r    <= 1'b0;
      data2_r <= {OW{1'b0}};
      last2_r <= 1'b0;
    end else if (adv2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        data2_r <= q_s;
        last2_r <= last1_r;
      end
    end
  end

`ifdef REQUANT_SAT_COUNT_EN
  logic        clamp_s;
  logic        sat2_r;
  logic [31:0] sat_count_r;

  assign clamp_s   = (r_s > OMAX_S) || (r_s < OMIN_S);
  assign sat_count = sat_count_r;

  // Saturation flag travels with the output beat.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sat2_r <= 1'b0;
    end else if (adv2_s && v1_r) begin
      sat2_r <= clamp_s;
    end
  end

  // Counts transferred saturated beats, sticking at all-ones.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sat_count_r <= 32'd0;
    end else if (v2_r && m_axis_output_tready && sat2_r && (sat_count_r != 32'hFFFF_FFFF)) begin
      sat_count_r <= sat_count_r + 32'd1;
    end
  end
`else
  assign sat_count = 32'd0;
`endif

endmodule

// File: tb/tb_stream_requantizer.sv
// Directed bench for stream_requantizer: a signed-output and an unsigned-output instance share stimulus.
module tb_stream_requantizer;

`ifdef REQUANT_SAT_COUNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic [4:0]  cfg_shift;
  logic        bias_wr_en;
  logic [1:0]  bias_wr_addr;
  logic [15:0] bias_wr_data;
  logic        out_ready;

  logic        a_ready, a_valid, a_last;
  logic [7:0]  a_data;
  logic [31:0] a_sat;
  logic        b_ready, b_valid, b_last;
  logic [7:0]  b_data;
  logic [31:0] b_sat;

  logic [7:0] q_data[$];
  logic       q_last[$];
  logic [7:0] q_uns[$];

  stream_requantizer #(.CHANNELS(4)) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_axis_input_tdata(in_data), .s_axis_input_tvalid(in_valid),
    .s_axis_input_tready(a_ready), .s_axis_input_tlast(in_last),
    .m_axis_output_tdata(a_data), .m_axis_output_tvalid(a_valid),
    .m_axis_output_tready(out_ready), .m_axis_output_tlast(a_last),
    .cfg_shift(cfg_shift), .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr),
    .bias_wr_data(bias_wr_data), .sat_count(a_sat)
  );

  stream_requantizer #(.CHANNELS(4), .m_axis_output_SIGNED(0)) u_uns (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_axis_input_tdata(in_data), .s_axis_input_tvalid(in_valid),
    .s_axis_input_tready(b_ready), .s_axis_input_tlast(in_last),
    .m_axis_output_tdata(b_data), .m_axis_output_tvalid(b_valid),
    .m_axis_output_tready(out_ready), .m_axis_output_tlast(b_last),
    .cfg_shift(cfg_shift), .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr),
    .bias_wr_data(bias_wr_data), .sat_count(b_sat)
  );

  always #5 ap_clk = ~ap_clk;

  // Record every output transfer; sampled mid-cycle, well before the next rising edge.
  always @(negedge ap_clk) begin
    #1;
    if (a_valid && out_ready) begin
      q_data.push_back(a_data);
      q_last.push_back(a_last);
    end
    if (b_valid && out_ready) begin
      q_uns.push_back(b_data);
    end
  end

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_uns.delete();
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    bias_wr_en = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge ap_clk);
  endtask

  task automatic write_bias(input logic [1:0] addr, input logic [15:0] val);
    bias_wr_en = 1'b1;
    bias_wr_addr = addr;
    bias_wr_data = val;
    @(negedge ap_clk);
    bias_wr_en = 1'b0;
  endtask

  // Present one beat at a falling edge and return at the falling edge after it is accepted.
  task automatic push(input logic [31:0] d, input logic l);
    int guard;
    guard = 0;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    #1;
    while (!a_ready && guard < 50) begin
      @(negedge ap_clk);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL push_timeout: ready stayed 0 for %0d cycles, want 1", guard);
    end
    @(negedge ap_clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 32'd0;
    cfg_shift = 5'd0; bias_wr_en = 1'b0; bias_wr_addr = 2'd0; bias_wr_data = 16'd0;
    out_ready = 1'b1;
    @(negedge ap_clk); #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %0b want 0", a_ready); end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", a_valid); end
    checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", a_data); end
    checks++; if (a_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b want 0", a_last); end
    checks++; if (a_sat !== 32'd0) begin errors++; $display("FAIL reset_sat: got %0d want 0", a_sat); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %0b want 1", a_ready); end
    @(negedge ap_clk);
  endtask

  task automatic test_rounding();
    clear_q();
    cfg_shift = 5'd4;
    in_data = 32'h0000_0123;
    in_last = 1'b0;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL round_latency1: valid %0b want 0", a_valid); end
    @(posedge ap_clk); #1;
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL round_latency2: valid %0b want 1", a_valid); end
    checks++; if (a_data !== 8'h12) begin errors++; $display("FAIL round_0x123: got %h want 12", a_data); end
    @(negedge ap_clk);
    cfg_shift = 5'd1;
    push(32'd3, 1'b0);
    push(32'hFFFF_FFFD, 1'b0);
    drain();
    checks++; if (q_data.size() !== 3) begin errors++; $display("FAIL round_count: got %0d want 3", q_data.size()); end
    if (q_data.size() == 3) begin
      checks++; if (q_data[1] !== 8'h02) begin errors++; $display("FAIL round_half_pos: got %h want 02", q_data[1]); end
      checks++; if (q_data[2] !== 8'hFF) begin errors++; $display("FAIL round_half_neg: got %h want ff", q_data[2]); end
    end
    checks++; if (a_sat !== 32'd0) begin errors++; $display("FAIL round_sat: got %0d want 0", a_sat); end
  endtask

  task automatic test_negative_saturation();
    clear_q();
    cfg_shift = 5'd3;
    push(32'hFFFF_FFDB, 1'b0);
    cfg_shift = 5'd0;
    push(32'd100000, 1'b0);
    drain();
    checks++; if (q_data.size() !== 2 || q_uns.size() !== 2) begin
      errors++; $display("FAIL neg_count: got %0d/%0d want 2/2", q_data.size(), q_uns.size());
    end
    if (q_data.size() == 2 && q_uns.size() == 2) begin
      checks++; if (q_data[0] !== 8'hFB) begin errors++; $display("FAIL neg_round: got %h want fb", q_data[0]); end
      checks++; if (q_data[1] !== 8'h7F) begin errors++; $display("FAIL sat_pos: got %h want 7f", q_data[1]); end
      checks++; if (q_uns[0] !== 8'h00) begin errors++; $display("FAIL uns_neg: got %h want 00", q_uns[0]); end
      checks++; if (q_uns[1] !== 8'hFF) begin errors++; $display("FAIL uns_pos: got %h want ff", q_uns[1]); end
    end
    checks++; if (a_sat !== (SAT_EN ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL sat_count_signed: got %0d want %0d", a_sat, SAT_EN ? 1 : 0);
    end
    checks++; if (b_sat !== (SAT_EN ? 32'd3 : 32'd0)) begin
      errors++; $display("FAIL sat_count_unsigned: got %0d want %0d", b_sat, SAT_EN ? 3 : 0);
    end
  endtask

  task automatic test_channel_wrap();
    logic [7:0] exp_d [13];
    logic       exp_l [13];
    exp_d = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd10, 8'd20, 8'd30, 8'd40};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) write_bias(2'(i), 16'(10 * (i + 1)));
    cfg_shift = 5'd0;
    clear_q();
    for (int i = 0; i < 6; i++) push(32'd0, 1'b0);
    push(32'd0, 1'b1);
    for (int i = 0; i < 6; i++) push(32'd0, (i == 1) ? 1'b1 : 1'b0);
    drain();
    checks++; if (q_data.size() !== 13) begin errors++; $display("FAIL chan_count: got %0d want 13", q_data.size()); end
    if (q_data.size() == 13) begin
      for (int i = 0; i < 13; i++) begin
        checks++; if (q_data[i] !== exp_d[i] || q_last[i] !== exp_l[i]) begin
          errors++;
          $display("FAIL chan_beat%0d: got %0d/last %0b want %0d/last %0b", i, q_data[i], q_last[i], exp_d[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int guard;
    logic rdy;
    do_reset();
    cfg_shift = 5'd0;
    clear_q();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_last = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_data = 32'(acc + 1);
      #1;
      rdy = a_ready;
      if (c >= 2) begin
        checks++; if (a_valid !== 1'b1 || a_data !== 8'd1) begin
          errors++; $display("FAIL stall_hold_c%0d: got valid %0b data %0d want 1/1", c, a_valid, a_data);
        end
      end
      @(posedge ap_clk);
      if (rdy) acc++;
      @(negedge ap_clk);
    end
    in_data = 32'(acc + 1);
    #1;
    checks++; if (acc !== 2) begin errors++; $display("FAIL stall_accepted: got %0d want 2", acc); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %0b want 0", a_ready); end
    @(negedge ap_clk);
    out_ready = 1'b1;
    guard = 0;
    while (acc < 5 && guard < 20) begin
      in_data = 32'(acc + 1);
      #1;
      rdy = a_ready;
      @(posedge ap_clk);
      if (rdy) acc++;
      @(negedge ap_clk);
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 20) begin
      checks++; errors++; $display("FAIL release_timeout: accepted %0d want 5", acc);
    end
    drain();
    checks++; if (q_data.size() !== 5) begin errors++; $display("FAIL release_count: got %0d want 5", q_data.size()); end
    if (q_data.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (q_data[i] !== 8'(i + 1)) begin
          errors++; $display("FAIL release_beat%0d: got %0d want %0d", i, q_data[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_bias_collision();
    do_reset();
    cfg_shift = 5'd0;
    clear_q();
    in_data = 32'd0;
    in_last = 1'b1;
    in_valid = 1'b1;
    bias_wr_en = 1'b1;
    bias_wr_addr = 2'd0;
    bias_wr_data = 16'd50;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL collide_ready: got %0b want 1", a_ready); end
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    bias_wr_en = 1'b0;
    @(negedge ap_clk);
    push(32'd0, 1'b0);
    drain();
    checks++; if (q_data.size() !== 2) begin errors++; $display("FAIL collide_count: got %0d want 2", q_data.size()); end
    if (q_data.size() == 2) begin
      checks++; if (q_data[0] !== 8'd0) begin errors++; $display("FAIL collide_old: got %0d want 0", q_data[0]); end
      checks++; if (q_data[1] !== 8'd50) begin errors++; $display("FAIL collide_new: got %0d want 50", q_data[1]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_bias(2'd0, 16'd7);
    cfg_shift = 5'd0;
    push(32'd100000, 1'b0);
    drain();
    out_ready = 1'b0;
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    #1;
    checks++; if (a_valid !== 1'b1 || a_ready !== 1'b0) begin
      errors++; $display("FAIL mid_buffered: got valid %0b ready %0b want 1/0", a_valid, a_ready);
    end
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b want 0", a_valid); end
    checks++; if (a_data !== 8'h00 || a_last !== 1'b0) begin
      errors++; $display("FAIL mid_outputs: got %h/%0b want 00/0", a_data, a_last);
    end
    checks++; if (a_sat !== 32'd0) begin errors++; $display("FAIL mid_sat: got %0d want 0", a_sat); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %0b want 0", a_ready); end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    out_ready = 1'b1;
    clear_q();
    for (int i = 1; i < 4; i++) write_bias(2'(i), 16'd100);
    push(32'd5, 1'b0);
    drain();
    checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL mid_count: got %0d want 1", q_data.size()); end
    if (q_data.size() == 1) begin
      checks++; if (q_data[0] !== 8'd5) begin errors++; $display("FAIL mid_first_beat: got %0d want 5", q_data[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_negative_saturation();
    test_channel_wrap();
    test_back_to_back();
    test_bias_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_requantizer.md
Name: stream_requantizer

Overview:
- Downstream stage of the datatype-parameterised compute kernel. Consumes its wide accumulator stream on s_axis_input and emits a narrow quantised stream on m_axis_output.
- Per beat: adds a per-channel bias, arithmetic-right-shifts with round-half-up, then saturates to the output datatype.
- Two-stage registered pipeline with full AXI-Stream backpressure.
- Interface datatype parameters follow the `<interface>_<PROPERTY>` convention so they auto-link without pragmas.

Parameters:
- s_axis_input_WIDTH, 32, input accumulator width.
- s_axis_input_SIGNED, 1, input is two's complement (0 = zero-extend).
- m_axis_output_WIDTH, 8, output width.
- m_axis_output_SIGNED, 1, output range signed (1) or unsigned (0).
- BIAS_WIDTH, 16, signed bias width.
- CHANNELS, 16, bias table depth; channel counter modulus (≥2).
- SHIFT_WIDTH, 5, width of cfg_shift.

Ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- s_axis_input_tdata  in  s_axis_input_WIDTH  accumulator value.
- s_axis_input_tvalid  in  1  input beat valid.
- s_axis_input_tready  out  1  input beat accepted.
- s_axis_input_tlast  in  1  end of vector.
- m_axis_output_tdata  out  m_axis_output_WIDTH  quantised value.
- m_axis_output_tvalid  out  1  output beat valid.
- m_axis_output_tready  in  1  downstream ready.
- m_axis_output_tlast  out  1  tlast passed through aligned to data.
- cfg_shift  in  SHIFT_WIDTH  right-shift amount, sampled per beat at acceptance.
- bias_wr_en  in  1  bias table write strobe.
- bias_wr_addr  in  clog2(CHANNELS)  bias entry index.
- bias_wr_data  in  BIAS_WIDTH  signed bias.
- sat_count  out  32  saturation event counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock, ap_clk. Reset ap_rst is synchronous, active-high.
- Reset values:
  - all valids 0; m_axis_output_tdata 0; m_axis_output_tlast 0;
  - channel counter 0; sat_count 0;
  - bias table cleared to 0.
- Handshake:
  - adv2 = !v2 | m_axis_output_tready; adv1 = !v1 | adv2; s_axis_input_tready = adv1.
  - Ready is combinational from m_axis_output_tready; no bubbles under continuous flow.
  - Capacity is 2 beats.
  - m_axis_output_tdata and m_axis_output_tlast hold stable while tvalid=1 and tready=0.
- Latency: 2 cycles from input accept to output tvalid when unstalled.
- Stage 1 (on accept):
  - x = input, sign- or zero-extended per s_axis_input_SIGNED to s_axis_input_WIDTH+2.
  - sum = x + sext(bias[ch]).
  - cfg_shift and tlast are registered alongside sum.
- Stage 2:
  - sh=0: r = sum.
  - sh>0: r = (sum + 2^(sh-1)) >>> sh (arithmetic, round-half-up).
  - sh ≥ width clamps to width-1.
- Saturation:
  - signed output: clamp to [-2^(W-1), 2^(W-1)-1].
  - unsigned output: clamp to [0, 2^W-1]; negative results go to 0.
  - Saturation flag set when a clamp occurs.
- Channel counter:
  - increments on each accepted input beat; wraps CHANNELS-1 → 0.
  - an accepted beat with tlast=1 forces the next channel to 0 (tlast wins over wrap).
- Bias write vs read, same cycle and same entry: stage 1 uses the old value; the new value applies from the next cycle.
- Writes with bias_wr_addr ≥ CHANNELS are ignored.
- cfg_shift may change at any time; each beat uses the value present at its acceptance.
- Reset asserted mid-stream: in-flight beats are discarded, outputs return to reset values the next cycle, and s_axis_input_tready is 0 while ap_rst=1.

Optional Feature:
- Macro: REQUANT_SAT_COUNT_EN.
- Defined:
  - sat_count increments once per output beat transferred with the saturation flag set.
  - It saturates at 2^32-1 and is cleared only by ap_rst.
- Undefined: sat_count is tied to 0 and the counter logic is absent.

Test Plan:
- Rounding: defaults, bias 0, cfg_shift=4, input 0x00000123 → output 0x12 (291+8=299, >>4 = 18) exactly 2 cycles after accept; sat_count unchanged.
- Negative rounding and saturation: cfg_shift=3, input -37 → 0xFB (-5). Then cfg_shift=0, input 100000 → 0x7F and sat_count=1 (macro on). With m_axis_output_SIGNED=0, input -37 → 0x00.
- Channel wrap and tlast: CHANNELS=4, biases {10,20,30,40}, cfg_shift=0, six input beats of 0 → 10,20,30,40,10,20. Repeat with tlast on beat 2 → 10,20,10,20,30,40; tlast appears on output beat 2 only.
- Backpressure: continuous valid with tready=0 for 5 cycles → exactly 2 beats accepted, s_axis_input_tready low, output held stable. Release tready → all beats delivered in order, no loss or duplication.
- Bias write collision: write bias[0]=50 in the same cycle a channel-0 beat of 0 is accepted → output 0 (old bias). The next channel-0 beat → 50.
- Reset mid-operation: assert ap_rst with 2 beats buffered → m_axis_output_tvalid=0 next cycle, channel 0, bias table 0, sat_count 0. After release the first beat uses bias 0.
